// File: rtl/cache_srw_assoc.sv
// N-way set-associative cache with simultaneous write and registered read ports,
// round-robin replacement, eviction reporting and a sequential flush engine.
module cache_srw_assoc #(
   parameter int IDX_BITS   = 2,
   parameter int NUM_WAYS   = 2,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   input  logic                  ce_i,
   input  logic                  flush_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  rhit_o,
   output logic                  rvalid_o,
   output logic                  busy_o,
   output logic                  evict_valid_o,
   output logic [ADDR_WIDTH-1:0] evict_addr_o,
   output logic [DATA_WIDTH-1:0] evict_data_o
);

   localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS;
   localparam int SETS     = 2 ** IDX_BITS;

   typedef enum logic {
      S_IDLE,
      S_FLUSH
   } state_t;

   state_t                state_q;
   logic [IDX_BITS-1:0]   flush_cnt_q;
   logic [NUM_WAYS-1:0]   valid_q [SETS];
   logic [WAY_BITS-1:0]   ptr_q   [SETS];
   logic [TAG_BITS-1:0]   tag_q   [SETS][NUM_WAYS];
   logic [DATA_WIDTH-1:0] data_q  [SETS][NUM_WAYS];

   logic                  rvalid_q;
   logic                  rhit_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  evict_valid_q;
   logic [ADDR_WIDTH-1:0] evict_addr_q;
   logic [DATA_WIDTH-1:0] evict_data_q;

   logic [IDX_BITS-1:0]   wr_idx;
   logic [TAG_BITS-1:0]   wr_tag;
   logic                  wr_accept;
   logic                  wr_hit;
   logic [WAY_BITS-1:0]   wr_hit_way;
   logic                  wr_inv;
   logic [WAY_BITS-1:0]   wr_inv_way;
   logic [WAY_BITS-1:0]   victim;
   logic [WAY_BITS-1:0]   ptr_d;
   logic [WAY_BITS-1:0]   wr_way;
   logic                  wr_evict;

   logic [IDX_BITS-1:0]   rd_idx;
   logic [TAG_BITS-1:0]   rd_tag;
   logic                  rd_hit_d;
   logic [DATA_WIDTH-1:0] rd_data_d;

   assign wr_idx    = waddr_i[IDX_BITS-1:0];
   assign wr_tag    = waddr_i[ADDR_WIDTH-1:IDX_BITS];
   assign wr_accept = we_i && (state_q == S_IDLE) && !flush_i;
   assign rd_idx    = raddr_i[IDX_BITS-1:0];
   assign rd_tag    = raddr_i[ADDR_WIDTH-1:IDX_BITS];

   // Way selection: hit first, then lowest invalid way, then the round-robin victim.
   always_comb begin
      wr_hit     = 1'b0;
      wr_hit_way = '0;
      wr_inv     = 1'b0;
      wr_inv_way = '0;
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[wr_idx][w] && (tag_q[wr_idx][w] == wr_tag)) begin
            wr_hit     = 1'b1;
            wr_hit_way = WAY_BITS'(w);
         end
         if (!valid_q[wr_idx][w] && !wr_inv) begin
            wr_inv     = 1'b1;
            wr_inv_way = WAY_BITS'(w);
         end
      end
      victim = ptr_q[wr_idx];
      ptr_d  = (victim == WAY_BITS'(NUM_WAYS - 1)) ? '0 : victim + 1'b1;
      if (wr_hit) begin
         wr_way = wr_hit_way;
      end else if (wr_inv) begin
         wr_way = wr_inv_way;
      end else begin
         wr_way = victim;
      end
      wr_evict = wr_accept && !wr_hit && !wr_inv;
   end

   // Lookup reads the arrays before this cycle's write lands, so an evicted line
   // still hits; only an exact address match is forwarded from the write port.
   always_comb begin
      rd_hit_d  = 1'b0;
      rd_data_d = '0;
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag)) begin
            rd_hit_d  = 1'b1;
            rd_data_d = data_q[rd_idx][w];
         end
      end
      if (wr_accept && (waddr_i == raddr_i)) begin
         rd_hit_d  = 1'b1;
         rd_data_d = wdata_i;
      end
      if (state_q == S_FLUSH) begin
         rd_hit_d  = 1'b0;
         rd_data_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         flush_cnt_q <= '0;
         for (int unsigned s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (flush_i) begin
                  state_q     <= S_FLUSH;
                  flush_cnt_q <= '0;
               end else if (wr_accept) begin
                  valid_q[wr_idx][wr_way] <= 1'b1;
                  if (wr_evict) begin
                     ptr_q[wr_idx] <= ptr_d;
                  end
               end
            end
            S_FLUSH: begin
               valid_q[flush_cnt_q] <= '0;
               flush_cnt_q          <= flush_cnt_q + 1'b1;
               if (flush_cnt_q == '1) begin
                  state_q <= S_IDLE;
                  for (int unsigned s = 0; s < SETS; s++) begin
                     ptr_q[s] <= '0;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_accept) begin
         tag_q[wr_idx][wr_way]  <= wr_tag;
         data_q[wr_idx][wr_way] <= wdata_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid_q      <= 1'b0;
         rhit_q        <= 1'b0;
         rdata_q       <= '0;
         evict_valid_q <= 1'b0;
         evict_addr_q  <= '0;
         evict_data_q  <= '0;
      end else begin
         rvalid_q      <= ce_i;
         evict_valid_q <= wr_evict;
         if (ce_i) begin
            rhit_q  <= rd_hit_d;
            rdata_q <= rd_data_d;
         end
         if (wr_evict) begin
            evict_addr_q <= {tag_q[wr_idx][victim], wr_idx};
            evict_data_q <= data_q[wr_idx][victim];
         end
      end
   end

   assign rdata_o       = rdata_q;
   assign rhit_o        = rhit_q;
   assign rvalid_o      = rvalid_q;
   assign busy_o        = (state_q == S_FLUSH);
   assign evict_valid_o = evict_valid_q;
   assign evict_addr_o  = evict_addr_q;
   assign evict_data_o  = evict_data_q;

endmodule

// File: doc/cache_srw_assoc.md
Name: cache_srw_assoc

Overview:
- N-way set-associative cache with one write port and one read port operating in the same cycle.
- Successor to the direct-mapped simultaneous read/write cache. Adds:
  - a way count parameter;
  - per-line valid bits;
  - round-robin replacement;
  - a registered read with a valid strobe;
  - an eviction report for write-back;
  - a runtime flush state machine.
- Used as a small tag-checked buffer in front of a register/memory stage.

Parameters:
- IDX_BITS, 2, set index width; 2**IDX_BITS sets.
- NUM_WAYS, 2, ways per set; power of two, at least 1. WAY_BITS = max(1, $clog2(NUM_WAYS)).
- DATA_WIDTH, 16, line data width.
- ADDR_WIDTH, 8, address width. Tag = addr[ADDR_WIDTH-1:IDX_BITS]; index = addr[IDX_BITS-1:0].

Ports:
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous active-high reset.
- waddr_i, in, ADDR_WIDTH, write address.
- wdata_i, in, DATA_WIDTH, write data.
- we_i, in, 1, write request.
- raddr_i, in, ADDR_WIDTH, read address.
- ce_i, in, 1, read request.
- flush_i, in, 1, start invalidation of all lines.
- rdata_o, out, DATA_WIDTH, read data; 0 on miss.
- rhit_o, out, 1, read hit.
- rvalid_o, out, 1, rdata_o/rhit_o valid for the read issued last cycle.
- busy_o, out, 1, flush in progress.
- evict_valid_o, out, 1, a valid line was overwritten last cycle.
- evict_addr_o, out, ADDR_WIDTH, address of the evicted line, {tag, index}.
- evict_data_o, out, DATA_WIDTH, data of the evicted line.

Behaviour:
- Reset (asynchronous, active-high):
  - all valid bits cleared, all round-robin pointers cleared, FSM to IDLE, flush counter cleared;
  - all outputs 0;
  - data and tag arrays are not reset.
- FSM has two states: IDLE and FLUSH.
  - IDLE -> FLUSH when flush_i=1. busy_o=1 from the next cycle.
  - In FLUSH, set flush_cnt is invalidated (all ways) each cycle and flush_cnt increments.
  - FLUSH -> IDLE after set 2**IDX_BITS-1 is cleared. The flush takes exactly 2**IDX_BITS cycles with busy_o=1.
  - flush_i is ignored while in FLUSH.
  - Round-robin pointers are cleared on flush completion.
- Write is accepted when we_i=1, state=IDLE and flush_i=0. Otherwise it is dropped silently.
  - Write hit (valid way whose tag matches): data is updated in place; pointer unchanged; no eviction.
  - Write miss, invalid way present: the lowest-index invalid way is allocated and set valid; pointer unchanged.
  - Write miss, set full: the victim is the way at the set's pointer; the pointer increments modulo NUM_WAYS.
  - On a full-set miss, the next cycle drives evict_valid_o=1 with the victim's old address and data. Otherwise evict_valid_o=0.
  - evict_addr_o/evict_data_o hold their value when evict_valid_o=0.
- Read is issued when ce_i=1. Latency is 1 cycle: rvalid_o=1 the following cycle, otherwise 0.
  - IDLE: rhit_o=1 if any valid way in the set matches the tag, and rdata_o is that way's data. On a miss, rhit_o=0 and rdata_o=0.
  - Issued while state=FLUSH: rvalid_o=1, rhit_o=0, rdata_o=0.
  - rdata_o/rhit_o hold their value when rvalid_o=0.
- Same-cycle read and write (write-first):
  - If an accepted write and a read target the same address, the read returns rhit_o=1 and rdata_o=wdata_i.
  - If the write is in the same set but to a different address and evicts the line being read, the read returns the pre-write contents (hit on the old line).
- flush_i and we_i in the same IDLE cycle: the write is dropped, with no forwarding. A read in that cycle is served from the pre-flush contents.
- Tags are unique within a set by construction: a write hit never allocates a second way.
- NUM_WAYS=1 degenerates to a direct-mapped cache; the pointer is constant 0 and every conflicting write evicts.

Test Plan:
(All scenarios use the defaults IDX_BITS=2, NUM_WAYS=2, ADDR_WIDTH=8, DATA_WIDTH=16.)
1. After reset: read 0x04 -> next cycle rvalid_o=1, rhit_o=0, rdata_o=0x0000; all other outputs 0.
2. Write 0x04/0xAAAA, then 0x08/0xBBBB (both set 0) -> reads of 0x04 and 0x08 hit with 0xAAAA and 0xBBBB; evict_valid_o stays 0.
3. Continue with write 0x0C/0xCCCC -> next cycle evict_valid_o=1, evict_addr_o=0x04, evict_data_o=0xAAAA. Read 0x04 misses; read 0x0C hits 0xCCCC. Then write 0x10/0xDDDD -> evicts 0x08/0xBBBB, because the pointer advanced to way 1.
4. Same cycle write 0x21/0x1234 and read 0x21 -> next cycle rhit_o=1, rdata_o=0x1234. Then write 0x21/0x5678 (hit) -> read returns 0x5678 with no eviction.
5. Fill several sets, then pulse flush_i -> busy_o=1 for exactly 4 cycles.
   - Writes during those cycles are dropped.
   - Reads during those cycles return rhit_o=0.
   - After busy_o falls, all prior addresses miss.
   - A new write 0x04 allocates way 0 without eviction.
6. Write 0x04/0xAAAA, then assert reset mid-flush -> all outputs 0 immediately, busy_o=0, FSM in IDLE. A read of 0x04 after release misses.
